// File: rtl/stk_pipe_dl.sv
// Dealloc front-end: buffers freed descriptor pointers and issues them to the allocator.
// Define STK_PIPE_DL_BYPASS_EN to forward a pointer straight through when the FIFO is empty.
package stk_pkg;
  localparam int PTR_W = 8;
endpackage

module stk_pipe_dl #(
  parameter int DEPTH_N = 4,
  parameter int PTR_W   = stk_pkg::PTR_W,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rt_vld,
  input  logic [PTR_W-1:0] i_rt_ptr,
  output logic             o_rt_rdy,
  input  logic             i_al_busy,
  input  logic             i_ad_alloc,
  output logic             o_dealloc_vld,
  output logic [PTR_W-1:0] o_dealloc_ptr,
  output logic [CNT_W-1:0] o_inflight_r,
  output logic             o_empty_r,
  output logic             o_err_r
);

  localparam int AW = $clog2(DEPTH_N);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH_N);

  logic [PTR_W-1:0] mem_q [DEPTH_N];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      occ_q, occ_d;
  logic             rdy_q, rdy_d;
  logic             empty_q, empty_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             byp, pop, push;

`ifdef STK_PIPE_DL_BYPASS_EN
  assign byp = empty_q & ~i_al_busy & i_rt_vld;
`else
  assign byp = 1'b0;
`endif

  assign pop  = ~empty_q & ~i_al_busy;
  assign push = i_rt_vld & rdy_q & ~byp;

  assign o_dealloc_vld = pop | byp;
  assign o_dealloc_ptr = byp ? i_rt_ptr : mem_q[rd_q];
  assign o_rt_rdy      = rdy_q;
  assign o_empty_r     = empty_q;
  assign o_inflight_r  = cnt_q;
  assign o_err_r       = err_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
    rdy_d   = (occ_d != FULL);
    empty_d = (occ_d == '0);
  end

  // Saturating outstanding count; any clamp is a sticky error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case ({i_ad_alloc, o_dealloc_vld})
      2'b10: begin
        if (&cnt_q) err_d = 1'b1;
        else        cnt_d = cnt_q + CNT_W'(1);
      end
      2'b01: begin
        if (cnt_q == '0) err_d = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= i_rt_ptr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      rdy_q   <= 1'b1;
      empty_q <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      rdy_q   <= rdy_d;
      empty_q <= empty_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_stk_pipe_dl.sv
// Scoreboard bench for stk_pipe_dl with a queue-based reference model.
// Small counter width so saturation is reachable.
module tb_stk_pipe_dl;
  localparam int DN = 4;
  localparam int PW = stk_pkg::PTR_W;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_rt_vld = 1'b0;
  logic [PW-1:0] i_rt_ptr = '0;
  logic          i_al_busy = 1'b0;
  logic          i_ad_alloc = 1'b0;
  logic          o_rt_rdy;
  logic          o_dealloc_vld;
  logic [PW-1:0] o_dealloc_ptr;
  logic [CW-1:0] o_inflight_r;
  logic          o_empty_r;
  logic          o_err_r;

  stk_pipe_dl #(.DEPTH_N(DN), .PTR_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_rt_vld(i_rt_vld), .i_rt_ptr(i_rt_ptr), .o_rt_rdy(o_rt_rdy),
    .i_al_busy(i_al_busy), .i_ad_alloc(i_ad_alloc),
    .o_dealloc_vld(o_dealloc_vld), .o_dealloc_ptr(o_dealloc_ptr),
    .o_inflight_r(o_inflight_r), .o_empty_r(o_empty_r), .o_err_r(o_err_r)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] mq[$];
  logic [PW-1:0] sb[$];
  int m_cnt = 0;
  bit m_err = 1'b0;

  bit chk = 1'b0;
  bit e_vld, e_rdy, e_empty, e_err;
  int e_cnt;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk) begin
        cmp("dealloc_vld", 32'(o_dealloc_vld), 32'(e_vld));
        cmp("rt_rdy", 32'(o_rt_rdy), 32'(e_rdy));
        cmp("empty", 32'(o_empty_r), 32'(e_empty));
        cmp("inflight", 32'(o_inflight_r), 32'(e_cnt));
        cmp("err", 32'(o_err_r), 32'(e_err));
        if (o_dealloc_vld === 1'b1) begin
          cmp("sb_nonempty", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0)
            cmp("dealloc_ptr", 32'(o_dealloc_ptr), 32'(sb.pop_front()));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    chk = 1'b0;
    rst = 1'b1;
    i_rt_vld = 1'b1;
    i_rt_ptr = PW'($urandom);
    i_al_busy = 1'b0;
    i_ad_alloc = 1'b1;
    mq.delete();
    sb.delete();
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic step(input bit v, input logic [PW-1:0] p,
                      input bit b, input bit a);
    bit pop, byp, push;
    int n;
    @(negedge clk);
    rst = 1'b0;
    i_rt_vld = v;
    i_rt_ptr = p;
    i_al_busy = b;
    i_ad_alloc = a;
    e_rdy = (mq.size() != DN);
    e_empty = (mq.size() == 0);
    e_cnt = m_cnt;
    e_err = m_err;
    pop = (mq.size() > 0) && !b;
    byp = 1'b0;
`ifdef STK_PIPE_DL_BYPASS_EN
    byp = (mq.size() == 0) && !b && v;
`endif
    push = v && e_rdy && !byp;
    e_vld = pop || byp;
    if (byp || push) sb.push_back(p);
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(p);
    n = m_cnt + int'(a) - int'(e_vld);
    if (n < 0) begin n = 0; m_err = 1'b1; end
    if (n > CMAX) begin n = CMAX; m_err = 1'b1; end
    m_cnt = n;
    chk = 1'b1;
  endtask

  task automatic rnd(input int cyc, input int vp, input int bp, input int ap);
    for (int i = 0; i < cyc; i++)
      step($urandom_range(99) < vp, PW'($urandom),
           $urandom_range(99) < bp, $urandom_range(99) < ap);
  endtask

  initial begin
    do_reset();
    do_reset();
    step(1, PW'(8'h05), 0, 1);
    repeat (3) step(0, '0, 0, 0);

    do_reset();
    for (int i = 1; i <= 4; i++) step(1, PW'(i), 1, 1);
    repeat (2) step(1, PW'(8'h09), 1, 0);
    repeat (6) step(0, '0, 0, 0);

    do_reset();
    repeat (4) step(0, '0, 0, 1);
    step(1, PW'(8'h01), 1, 0);
    step(1, PW'(8'h02), 1, 0);
    for (int i = 0; i < 6; i++) step(1, PW'(8'h0A + i), 0, 0);

    do_reset();
    repeat (3) step(0, '0, 0, 1);
    step(1, PW'(8'h11), 1, 0);
    step(1, PW'(8'h12), 1, 0);
    step(1, PW'(8'h13), 0, 1);
    repeat (4) step(0, '0, 0, 0);

    do_reset();
    step(1, PW'(8'h07), 0, 0);
    repeat (4) step(0, '0, 0, 0);

    do_reset();
    repeat (20) step(0, '0, 0, 1);

    do_reset();
    repeat (3) step(1, PW'($urandom), 1, 1);
    do_reset();
    repeat (2) step(0, '0, 0, 0);

    do_reset();
    rnd(400, 70, 30, 55);
    do_reset();
    rnd(400, 90, 70, 50);
    do_reset();
    rnd(300, 40, 10, 30);

    @(negedge clk);
    chk = 1'b0;
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
